mdio_slave: RTL and testbench
=============================

MDIO_SLAVE -- requirements
Module: mdio_slave

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd1, the PHY address this responder answers to.
REQ-002 SHALL have parameter PRE_LEN, default 32, the number of consecutive preamble ones required before ST.
REQ-003 SHALL have port sys_clk  input  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port sys_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mdc  input  1  management clock from the station; asynchronous to sys_clk.
REQ-006 SHALL have port mdio  inout  1  management data; driven only during read TA bit 2 and read data, high-Z otherwise.
REQ-007 SHALL have port reg_wr_pulse  output  1  one-cycle pulse when a write frame completes.
REQ-008 SHALL have port reg_wr_addr  output  5  REGAD of the last completed write.
REQ-009 SHALL have port reg_wr_data  output  16  data of the last completed write.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a malformed frame addressed to any PHY.
REQ-011 SHALL have port busy  output  1  high from the ST bit 0 sample to the end of the frame.

Function
REQ-012 SHALL synchronize mdc and mdio through 2 flip-flops each, and detect mdc rising and falling edges on the synchronized mdc.
REQ-013 SHALL sample mdio only on detected mdc rising edges.
REQ-014 SHALL change its driven mdio only on detected mdc falling edges, within 4 sys_clk of the edge at the pin.
REQ-015 SHALL operate correctly for an mdc period of 8 sys_clk or longer, with duty cycle 40-60%.
REQ-016 SHALL hold a 32x16 register file, with every entry resetting to 16'h0000.
REQ-017 SHALL use FSM states PRE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA.
REQ-018 PRE: a sampled 1 SHALL increment the ones counter, saturating at PRE_LEN.
REQ-019 PRE: a sampled 0 with counter = PRE_LEN SHALL be taken as ST bit 0 and move the FSM to ST.
REQ-020 PRE: a sampled 0 with counter < PRE_LEN SHALL clear the counter and keep the FSM in PRE, with no error.
REQ-021 ST: a sampled 1 SHALL move to OP; a sampled 0 SHALL pulse frame_err and return to PRE.
REQ-022 OP: SHALL capture 2 bits MSB-first; 01 is write, 10 is read, and 00/11 SHALL pulse frame_err and return to PRE.
REQ-023 PHYAD then REGAD: SHALL capture 5 bits each, MSB-first.
REQ-024 A PHYAD mismatch SHALL set an internal ignore flag: no drive, no register write, no frame_err for the rest of the frame.
REQ-025 Write TA: SHALL sample 2 bits that must equal 10; otherwise frame_err pulses (unless ignored) and the FSM returns to PRE.
REQ-026 Read TA: mdio SHALL stay high-Z for TA bit 1.
REQ-027 Read TA: on the falling edge after TA bit 1, mdio SHALL be driven 0 (unless ignored).
REQ-028 WDATA: SHALL shift in 16 bits MSB-first.
REQ-029 WDATA: after the 16th sample, SHALL write regfile[REGAD], update reg_wr_addr/reg_wr_data, and pulse reg_wr_pulse exactly 1 cycle; none of these when ignored.
REQ-030 RDATA: SHALL load a shift register from regfile[REGAD] at the TA bit 2 falling edge and drive data MSB-first, one bit per mdc falling edge.
REQ-031 RDATA: SHALL release mdio on the falling edge after bit 0 has been driven a full mdc cycle.
REQ-032 After any completed or aborted frame, SHALL return to PRE with the ones counter cleared.
REQ-033 A write to the same REGAD during a later read frame SHALL NOT occur, as frames are serialized; a read SHALL always return the latest completed write.

Reset
REQ-034 On sys_rst assertion, SHALL enter PRE asynchronously and release mdio (high-Z) immediately.
REQ-035 On reset, SHALL set reg_wr_pulse, frame_err and busy = 0, reg_wr_addr = 0 and reg_wr_data = 0, clear the regfile, and clear the synchronizers.
REQ-036 Reset mid-frame SHALL abort the frame with no register update.
REQ-037 After reset, the next frame SHALL require a full PRE_LEN preamble.

Verification
REQ-038 Write: preamble, ST 01, OP 01, PHYAD 1, REGAD 5'h03, TA 10, data 16'hA5C3 -> one reg_wr_pulse, reg_wr_addr = 3, reg_wr_data = A5C3, mdio never driven.
REQ-039 Read-back: read frame of REGAD 3 with mdc = 16 sys_clk -> TA bit 1 Z, TA bit 2 = 0, then 1010010111000011 sampled at the master's mdc rising edges, then Z.
REQ-040 Wrong PHY: write PHYAD 2, data 16'hFFFF to REGAD 3 -> no pulse, no frame_err; a subsequent read of REGAD 3 returns A5C3.
REQ-041 Short preamble and bad OP: 31 ones then 01... -> frame ignored; full preamble then OP 11 -> one frame_err pulse, FSM back in PRE.
REQ-042 Reset mid-read at data bit 7 -> mdio Z within 1 cycle; a following read of REGAD 3 returns 0000.
REQ-043 Minimum mdc period: back-to-back write/read at mdc = 8 sys_clk, no idle gap -> both frames correct.

Source files
------------

// File: rtl/mdio_slave_if.sv
// Bus bundle between an MDIO station and the mdio_slave responder.
// mdio is the shared pin; the responder takes priority while it drives, otherwise the station's drive or high-Z.
interface mdio_slave_if;
    logic        mdc;
    wire         mdio;
    logic        mdio_oe;
    logic        mdio_do;
    logic        mst_oe;
    logic        mst_do;
    logic        reg_wr_pulse;
    logic [4:0]  reg_wr_addr;
    logic [15:0] reg_wr_data;
    logic        frame_err;
    logic        busy;

    assign mdio = mdio_oe ? mdio_do : (mst_oe ? mst_do : 1'bz);

    modport slave (
        input  mdc,
        input  mdio,
        output mdio_oe,
        output mdio_do,
        output reg_wr_pulse,
        output reg_wr_addr,
        output reg_wr_data,
        output frame_err,
        output busy
    );

    modport master (
        output mdc,
        output mst_oe,
        output mst_do,
        input  mdio,
        input  mdio_oe,
        input  reg_wr_pulse,
        input  reg_wr_addr,
        input  reg_wr_data,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/mdio_slave.sv
// Clause-22 MDIO responder with a 32x16 register file, oversampling mdc/mdio on sys_clk.
// Samples on synchronized mdc rising edges, changes its drive on synchronized falling edges.
module mdio_slave #(
    parameter logic [4:0] PHY_ADDR = 5'd1,
    parameter int         PRE_LEN  = 32
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    mdio_slave_if.slave bus
);
    localparam int             CW      = $clog2(PRE_LEN + 1);
    localparam logic [CW-1:0]  PRE_MAX = CW'(PRE_LEN);

    typedef enum logic [2:0] {
        S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    mdc_q;
    logic [1:0]    mdio_q;
    logic [CW-1:0] ones_q, ones_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [15:0]   sh_q, sh_d;
    logic          rd_q, rd_d;
    logic          ign_q, ign_d;
    logic [4:0]    regad_q, regad_d;
    logic          oe_q, oe_d;
    logic          do_q, do_d;
    logic          wrp_q, wrp_d;
    logic [4:0]    wra_q, wra_d;
    logic [15:0]   wrd_q, wrd_d;
    logic          err_q, err_d;
    logic [15:0]   regs_q [32];
    logic          wr_en;
    logic          rise, fall, mdio_s;
    logic [15:0]   wval;

    // mdc_q[2] is the previous synchronized mdc, so edges line up with mdio_q[1]
    assign rise   = mdc_q[1] & ~mdc_q[2];
    assign fall   = ~mdc_q[1] & mdc_q[2];
    assign mdio_s = mdio_q[1];
    assign wval   = {sh_q[14:0], mdio_s};

    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        rd_d    = rd_q;
        ign_d   = ign_q;
        regad_d = regad_q;
        oe_d    = oe_q;
        do_d    = do_q;
        wrp_d   = 1'b0;
        wra_d   = wra_q;
        wrd_d   = wrd_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        if (rise) begin
            case (state_q)
                S_PRE: begin
                    if (mdio_s) begin
                        if (ones_q != PRE_MAX) ones_d = ones_q + 1'b1;
                    end else if (ones_q == PRE_MAX) begin
                        state_d = S_ST;
                        ones_d  = '0;
                        ign_d   = 1'b0;
                    end else begin
                        ones_d = '0;
                    end
                end
                S_ST: begin
                    if (mdio_s) begin
                        state_d = S_OP;
                        cnt_d   = 5'd0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_PRE;
                    end
                end
                S_OP: begin
                    if (cnt_q == 5'd0) begin
                        sh_d  = wval;
                        cnt_d = 5'd1;
                    end else begin
                        cnt_d = 5'd0;
                        case ({sh_q[0], mdio_s})
                            2'b01:   begin rd_d = 1'b0; state_d = S_PHYAD; end
                            2'b10:   begin rd_d = 1'b1; state_d = S_PHYAD; end
                            default: begin err_d = 1'b1; state_d = S_PRE; end
                        endcase
                    end
                end
                S_PHYAD: begin
                    sh_d = wval;
                    if (cnt_q == 5'd4) begin
                        ign_d   = (wval[4:0] != PHY_ADDR);
                        cnt_d   = 5'd0;
                        state_d = S_REGAD;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                S_REGAD: begin
                    sh_d = wval;
                    if (cnt_q == 5'd4) begin
                        regad_d = wval[4:0];
                        cnt_d   = 5'd0;
                        state_d = S_TA;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                S_TA: begin
                    if (rd_q) begin
                        if (cnt_q == 5'd0) cnt_d = 5'd1;
                    end else if (cnt_q == 5'd0) begin
                        if (mdio_s) begin
                            cnt_d = 5'd1;
                        end else begin
                            err_d   = ~ign_q;
                            state_d = S_PRE;
                        end
                    end else if (!mdio_s) begin
                        cnt_d   = 5'd0;
                        state_d = S_WDATA;
                    end else begin
                        err_d   = ~ign_q;
                        cnt_d   = 5'd0;
                        state_d = S_PRE;
                    end
                end
                S_WDATA: begin
                    sh_d = wval;
                    if (cnt_q == 5'd15) begin
                        if (!ign_q) begin
                            wr_en = 1'b1;
                            wrp_d = 1'b1;
                            wra_d = regad_q;
                            wrd_d = wval;
                        end
                        cnt_d   = 5'd0;
                        state_d = S_PRE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                default: ;
            endcase
        end else if (fall) begin
            case (state_q)
                S_TA: begin
                    // TA bit 1 has been sampled: take the bus for TA bit 2
                    if (rd_q && cnt_q == 5'd1) begin
                        oe_d    = ~ign_q;
                        do_d    = 1'b0;
                        sh_d    = regs_q[regad_q];
                        cnt_d   = 5'd0;
                        state_d = S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (cnt_q == 5'd16) begin
                        oe_d    = 1'b0;
                        do_d    = 1'b0;
                        cnt_d   = 5'd0;
                        state_d = S_PRE;
                    end else begin
                        do_d  = sh_q[15];
                        sh_d  = {sh_q[14:0], 1'b0};
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= S_PRE;
            mdc_q   <= '0;
            mdio_q  <= '0;
            ones_q  <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            rd_q    <= 1'b0;
            ign_q   <= 1'b0;
            regad_q <= '0;
            oe_q    <= 1'b0;
            do_q    <= 1'b0;
            wrp_q   <= 1'b0;
            wra_q   <= '0;
            wrd_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            mdc_q   <= {mdc_q[1:0], bus.mdc};
            mdio_q  <= {mdio_q[0], bus.mdio};
            ones_q  <= ones_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            rd_q    <= rd_d;
            ign_q   <= ign_d;
            regad_q <= regad_d;
            oe_q    <= oe_d;
            do_q    <= do_d;
            wrp_q   <= wrp_d;
            wra_q   <= wra_d;
            wrd_q   <= wrd_d;
            err_q   <= err_d;
            if (wr_en) regs_q[regad_q] <= wval;
        end
    end

    assign bus.mdio_oe      = oe_q;
    assign bus.mdio_do      = do_q;
    assign bus.reg_wr_pulse = wrp_q;
    assign bus.reg_wr_addr  = wra_q;
    assign bus.reg_wr_data  = wrd_q;
    assign bus.frame_err    = err_q;
    assign bus.busy         = (state_q != S_PRE);
endmodule

// File: tb/tb_mdio_slave.sv
// Directed bench for mdio_slave: the bench acts as MDIO station and keeps a register-file model.
// Read-frame pin expectations are queued from the model and popped at each station mdc rising edge.
module tb_mdio_slave;
  localparam logic [4:0] PHY     = 5'd1;
  localparam int         PRE_LEN = 32;

  logic sys_clk = 1'b0;
  logic sys_rst;

  mdio_slave_if bus ();

  mdio_slave #(.PHY_ADDR(PHY), .PRE_LEN(PRE_LEN)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_wrp = 0;
  int          n_ferr = 0;
  int          half = 8;
  logic        any_drv;
  logic [15:0] model [32];
  logic [1:0]  sb [$];

  always @(negedge sys_clk) begin
    if (bus.reg_wr_pulse) n_wrp <= n_wrp + 1;
    if (bus.frame_err)    n_ferr <= n_ferr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One mdc period from falling edge to falling edge; the pin is sampled at the rising edge.
  task automatic mdc_bit(input logic oe, input logic v, output logic [1:0] obs);
    bus.mst_oe = oe;
    bus.mst_do = v;
    #(half * 10);
    bus.mdc = 1'b1;
    obs = {bus.mdio_oe, bus.mdio_oe & bus.mdio};
    any_drv = any_drv | bus.mdio_oe;
    #(half * 10);
    bus.mdc = 1'b0;
  endtask

  task automatic send(input logic [31:0] val, input int n);
    logic [1:0] obs;
    for (int i = n - 1; i >= 0; i--) mdc_bit(1'b1, val[i], obs);
  endtask

  task automatic frame(input int npre, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] rg, input logic [15:0] wd, input int abort_at);
    logic [1:0]  obs;
    logic [1:0]  exp;
    logic [15:0] rexp;
    logic        acc;
    bit          aborted;
    aborted = 1'b0;
    any_drv = 1'b0;
    for (int i = 0; i < npre; i++) mdc_bit(1'b1, 1'b1, obs);
    send(32'h1, 2);
    send({30'b0, op}, 2);
    if (op == 2'b01 || op == 2'b10) begin
      send({27'b0, phy}, 5);
      chk("busy_mid", {31'b0, bus.busy}, {31'b0, (npre >= PRE_LEN)});
      send({27'b0, rg}, 5);
      acc = (npre >= PRE_LEN) && (phy == PHY);
      if (op == 2'b01) begin
        send(32'h2, 2);
        send({16'b0, wd}, 16);
        if (acc) model[rg] = wd;
      end else begin
        rexp = model[rg];
        sb.push_back(2'b00);
        sb.push_back(acc ? 2'b10 : 2'b00);
        for (int i = 15; i >= 0; i--) sb.push_back(acc ? {1'b1, rexp[i]} : 2'b00);
        sb.push_back(2'b00);
        for (int k = 0; k < 19 && !aborted; k++) begin
          mdc_bit(1'b0, 1'b0, obs);
          exp = sb.pop_front();
          chk($sformatf("rd_pin%0d", k), {30'b0, obs}, {30'b0, exp});
          if (k == abort_at) begin
            sys_rst = 1'b1;
            #1;
            chk("rst_mdio_z", {31'b0, bus.mdio_oe}, 32'h0);
            chk("rst_busy", {31'b0, bus.busy}, 32'h0);
            chk("rst_wr_addr", {27'b0, bus.reg_wr_addr}, 32'h0);
            chk("rst_wr_data", {16'b0, bus.reg_wr_data}, 32'h0);
            sb.delete();
            for (int i = 0; i < 32; i++) model[i] = 16'h0000;
            #29;
            sys_rst = 1'b0;
            aborted = 1'b1;
          end
        end
      end
    end
  endtask

  initial begin
    int w0;
    int f0;
    sys_rst    = 1'b1;
    bus.mdc    = 1'b0;
    bus.mst_oe = 1'b0;
    bus.mst_do = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 16'h0000;
    #12;
    chk("init_mdio_z", {31'b0, bus.mdio_oe}, 32'h0);
    chk("init_wr_pulse", {31'b0, bus.reg_wr_pulse}, 32'h0);
    chk("init_frame_err", {31'b0, bus.frame_err}, 32'h0);
    chk("init_busy", {31'b0, bus.busy}, 32'h0);
    chk("init_wr_addr", {27'b0, bus.reg_wr_addr}, 32'h0);
    chk("init_wr_data", {16'b0, bus.reg_wr_data}, 32'h0);
    #10;
    sys_rst = 1'b0;

    // write A5C3 to REGAD 3, then read it back at mdc = 16 sys_clk
    half = 8;
    w0 = n_wrp; f0 = n_ferr;
    frame(32, 2'b01, PHY, 5'd3, 16'hA5C3, -1);
    #100;
    chk("wr_pulses", n_wrp - w0, 1);
    chk("wr_ferr", n_ferr - f0, 0);
    chk("wr_addr", {27'b0, bus.reg_wr_addr}, 32'h3);
    chk("wr_data", {16'b0, bus.reg_wr_data}, 32'hA5C3);
    chk("wr_no_drive", {31'b0, any_drv}, 32'h0);
    frame(32, 2'b10, PHY, 5'd3, 16'h0, -1);
    #50;
    chk("rd_busy_end", {31'b0, bus.busy}, 32'h0);

    // frames for another PHY are ignored entirely
    w0 = n_wrp; f0 = n_ferr;
    frame(32, 2'b01, 5'd2, 5'd3, 16'hFFFF, -1);
    #100;
    chk("wp_pulses", n_wrp - w0, 0);
    chk("wp_ferr", n_ferr - f0, 0);
    chk("wp_no_drive", {31'b0, any_drv}, 32'h0);
    chk("wp_wr_data", {16'b0, bus.reg_wr_data}, 32'hA5C3);
    frame(32, 2'b10, PHY, 5'd3, 16'h0, -1);
    frame(32, 2'b10, 5'd2, 5'd3, 16'h0, -1);

    // short preamble is silently ignored; OP 11 gives one frame_err
    w0 = n_wrp; f0 = n_ferr;
    frame(31, 2'b01, PHY, 5'd3, 16'h1234, -1);
    #100;
    chk("sp_pulses", n_wrp - w0, 0);
    chk("sp_ferr", n_ferr - f0, 0);
    frame(32, 2'b11, PHY, 5'd3, 16'h0, -1);
    #100;
    chk("op11_ferr", n_ferr - f0, 1);
    chk("op11_busy", {31'b0, bus.busy}, 32'h0);
    frame(32, 2'b10, PHY, 5'd3, 16'h0, -1);

    // reset in the middle of a read at data bit 7, then the cleared register reads back
    frame(32, 2'b10, PHY, 5'd3, 16'h0, 10);
    frame(32, 2'b10, PHY, 5'd3, 16'h0, -1);

    // minimum mdc period, back-to-back write and read
    half = 4;
    w0 = n_wrp; f0 = n_ferr;
    frame(32, 2'b01, PHY, 5'd5, 16'h3C5A, -1);
    frame(32, 2'b10, PHY, 5'd5, 16'h0, -1);
    #100;
    chk("fast_pulses", n_wrp - w0, 1);
    chk("fast_ferr", n_ferr - f0, 0);
    chk("fast_wr_addr", {27'b0, bus.reg_wr_addr}, 32'h5);
    chk("fast_wr_data", {16'b0, bus.reg_wr_data}, 32'h3C5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
